// File: rtl/sram_bist_ctrl.sv
// sram_bist_ctrl
//   March C- built-in self-test controller for a single-port SRAM with
//   registered read data. It owns the SRAM pins while a test runs. At all
//   other times it passes the functional port straight through.
//
//   March sequence ("0" = DATA_BG, "1" = ~DATA_BG):
//     M0 up(w0)  M1 up(r0,w1)  M2 up(r1,w0)
//     M3 down(r0,w1)  M4 down(r1,w0)  M5 up(r0)
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   bist_start          start pulse, honoured only when not busy
//   bist_busy           test in progress (M0..DRAIN)
//   bist_done           test finished; held until next start or reset
//   bist_fail           sticky mismatch flag for the current run
//   fail_addr/fail_elem address and March element (1..5) of first mismatch
//   func_*              functional SRAM port (dropped while busy)
//   func_dout           SRAM read data, always forwarded
//   mem_*               SRAM pins
module sram_bist_ctrl #(
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_WIDTH = 8,
  parameter int MEM_BITW  = 10,
  parameter logic [MEM_WIDTH-1:0] DATA_BG = {MEM_WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bist_start,
  output logic                 bist_busy,
  output logic                 bist_done,
  output logic                 bist_fail,
  output logic [MEM_BITW-1:0]  fail_addr,
  output logic [2:0]           fail_elem,
  input  logic                 func_csn,
  input  logic                 func_we,
  input  logic [MEM_BITW-1:0]  func_addr,
  input  logic [MEM_WIDTH-1:0] func_din,
  output logic [MEM_WIDTH-1:0] func_dout,
  output logic                 mem_csn,
  output logic                 mem_we,
  output logic [MEM_BITW-1:0]  mem_addr,
  output logic [MEM_WIDTH-1:0] mem_din,
  input  logic [MEM_WIDTH-1:0] mem_dout
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_t;

  localparam logic [MEM_BITW-1:0]  LAST_ADDR = MEM_BITW'(MEM_DEPTH - 1);
  localparam logic [MEM_WIDTH-1:0] BG0       = DATA_BG;
  localparam logic [MEM_WIDTH-1:0] BG1       = ~DATA_BG;

  state_t               state_reg, state_next;
  logic [MEM_BITW-1:0]  addr_reg, addr_next;
  logic                 wr_phase_reg, wr_phase_next;  // second cycle of a r/w pair

  logic                 fail_reg;
  logic [MEM_BITW-1:0]  fail_addr_reg;
  logic [2:0]           fail_elem_reg;

  // One-deep compare pipeline: what the read issued last cycle should return.
  logic                 cmp_valid_reg;
  logic [MEM_WIDTH-1:0] cmp_exp_reg;
  logic [MEM_BITW-1:0]  cmp_addr_reg;
  logic [2:0]           cmp_elem_reg;

  // Per-cycle controller decode
  logic                 bist_csn, bist_we;
  logic [MEM_WIDTH-1:0] bist_din;
  logic                 rd_issue;
  logic [MEM_WIDTH-1:0] rd_val, wr_val;
  logic [2:0]           elem;
  logic                 down;
  logic                 at_end;
  state_t               elem_next;
  logic [MEM_BITW-1:0]  elem_start;
  logic                 mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      wr_phase_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      wr_phase_reg <= wr_phase_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    wr_phase_next = wr_phase_reg;
    bist_csn      = 1'b1;
    bist_we       = 1'b0;
    bist_din      = BG0;
    rd_issue      = 1'b0;
    rd_val        = BG0;
    wr_val        = BG0;
    elem          = 3'd0;
    down          = 1'b0;
    elem_next     = S_DRAIN;
    elem_start    = '0;

    // Element attributes: expected read, write value, direction, successor.
    case (state_reg)
      S_M1: begin elem = 3'd1; rd_val = BG0; wr_val = BG1; elem_next = S_M2; end
      S_M2: begin elem = 3'd2; rd_val = BG1; wr_val = BG0; elem_next = S_M3;
                  elem_start = LAST_ADDR; end
      S_M3: begin elem = 3'd3; rd_val = BG0; wr_val = BG1; down = 1'b1;
                  elem_next = S_M4; elem_start = LAST_ADDR; end
      S_M4: begin elem = 3'd4; rd_val = BG1; wr_val = BG0; down = 1'b1;
                  elem_next = S_M5; end
      S_M5: begin elem = 3'd5; rd_val = BG0; end
      default: ;
    endcase

    at_end = down ? (addr_reg == '0) : (addr_reg == LAST_ADDR);

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (bist_start) begin
          state_next    = S_M0;
          addr_next     = '0;
          wr_phase_next = 1'b0;
        end
      end
      S_M0: begin
        bist_csn = 1'b0;
        bist_we  = 1'b1;
        bist_din = BG0;
        if (at_end) begin
          state_next = S_M1;
          addr_next  = '0;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end
      S_M1, S_M2, S_M3, S_M4: begin
        bist_csn = 1'b0;
        if (!wr_phase_reg) begin
          rd_issue      = 1'b1;
          wr_phase_next = 1'b1;
        end else begin
          bist_we       = 1'b1;
          bist_din      = wr_val;
          wr_phase_next = 1'b0;
          if (at_end) begin
            state_next = elem_next;
            addr_next  = elem_start;
          end else begin
            addr_next = down ? addr_reg - 1'b1 : addr_reg + 1'b1;
          end
        end
      end
      S_M5: begin
        bist_csn = 1'b0;
        rd_issue = 1'b1;
        if (at_end) state_next = S_DRAIN;
        else        addr_next  = addr_reg + 1'b1;
      end
      S_DRAIN: state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  assign mismatch = cmp_valid_reg && (mem_dout != cmp_exp_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_reg      <= 1'b0;
      fail_addr_reg <= '0;
      fail_elem_reg <= 3'd0;
      cmp_valid_reg <= 1'b0;
      cmp_exp_reg   <= '0;
      cmp_addr_reg  <= '0;
      cmp_elem_reg  <= 3'd0;
    end else begin
      cmp_valid_reg <= rd_issue;
      cmp_exp_reg   <= rd_val;
      cmp_addr_reg  <= addr_reg;
      cmp_elem_reg  <= elem;
      if ((state_reg == S_IDLE || state_reg == S_DONE) && bist_start) begin
        fail_reg      <= 1'b0;
        fail_addr_reg <= '0;
        fail_elem_reg <= 3'd0;
      end else if (mismatch) begin
        fail_reg <= 1'b1;
        if (!fail_reg) begin
          fail_addr_reg <= cmp_addr_reg;
          fail_elem_reg <= cmp_elem_reg;
        end
      end
    end
  end

  assign bist_busy = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign bist_done = (state_reg == S_DONE);
  assign bist_fail = fail_reg;
  assign fail_addr = fail_addr_reg;
  assign fail_elem = fail_elem_reg;
  assign func_dout = mem_dout;

  // Functional traffic is simply dropped while the test owns the SRAM.
  assign mem_csn  = bist_busy ? bist_csn : func_csn;
  assign mem_we   = bist_busy ? bist_we  : func_we;
  assign mem_addr = bist_busy ? addr_reg : func_addr;
  assign mem_din  = bist_busy ? bist_din : func_din;

endmodule
